// File: rtl/mips_pkg.sv
// Shared MIPS system definitions: IMEM geometry, data widths and the
// loader state encoding used by imem_loader.
package mips_pkg;

    localparam int IMEM_DEPTH     = 64;
    localparam int IMEM_ADDR_W    = 6;
    localparam int BYTE_W         = 8;
    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = INSTR_W / BYTE_W;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

endpackage

// File: rtl/imem_loader_assembler.sv
// Byte-to-word assembler for the IMEM loader: collects bytes MSB first,
// tracks the byte position inside the word and keeps a running XOR of
// every accepted byte.
module imem_loader_assembler
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               accept,
    input  logic [BYTE_W-1:0]  data_byte,
    output logic               word_ready,
    output logic [INSTR_W-1:0] word,
    output logic [BYTE_W-1:0]  checksum
);

    localparam int SHIFT_W = INSTR_W - BYTE_W;
    localparam int IDX_W   = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    // Only the first three bytes need storage; the fourth is taken
    // straight from the input on the cycle it is accepted.
    logic [SHIFT_W-1:0] shift_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BYTE_W-1:0]  csum_q;

    // Shift in accepted bytes, advance the byte index and fold into the checksum.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst || clr) begin
            shift_q <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
        end else if (accept) begin
            shift_q <= {shift_q[SHIFT_W-BYTE_W-1:0], data_byte};
            idx_q   <= idx_q + IDX_W'(1);
            csum_q  <= csum_q ^ data_byte;
        end
    end

    assign word_ready = accept && (idx_q == LAST_IDX);
    assign word       = {shift_q, data_byte};
    assign checksum   = csum_q;

endmodule

// File: rtl/imem_loader.sv
// IMEM loader: receives a length-prefixed, checksummed byte image, writes
// it word by word into IMEM and releases the MIPS core from reset only
// once the whole image has been verified.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int WORD_W = INSTR_W
) (
    input  logic              i_clk_w,
    input  logic              i_rst_w,
    input  logic              i_start_w,
    input  logic              i_byte_valid_w,
    input  logic [7:0]        i_byte_w,
    output logic              o_byte_ready_w,
    output logic              o_we_w,
    output logic [ADDR_W-1:0] o_addr_w,
    output logic [WORD_W-1:0] o_wdata_w,
    output logic              o_cpu_rst_w,
    output logic              o_done_w,
    output logic              o_error_w
);

    loader_state_e        state_q;
    logic [ADDR_W-1:0]    last_addr_q;

    logic                 transfer;
    logic                 start_ok;
    logic                 count_bad;
    logic                 asm_accept;
    logic                 asm_word_ready;
    logic [INSTR_W-1:0]   asm_word;
    logic [BYTE_W-1:0]    asm_checksum;

    assign transfer   = i_byte_valid_w && o_byte_ready_w;
    assign start_ok   = i_start_w && (state_q inside {IDLE, DONE, ERROR});
    assign count_bad  = (i_byte_w == 8'd0) || (int'(i_byte_w) > DEPTH);
    assign asm_accept = transfer && (state_q == DATA);

    imem_loader_assembler u_assembler (
        .clk        (i_clk_w),
        .rst        (i_rst_w),
        .clr        (start_ok),
        .accept     (asm_accept),
        .data_byte  (i_byte_w),
        .word_ready (asm_word_ready),
        .word       (asm_word),
        .checksum   (asm_checksum)
    );

    // Loader FSM with registered handshake, IMEM write port and status outputs.
    always_ff @(posedge i_clk_w) begin
        if (i_rst_w) begin
            state_q        <= IDLE;
            last_addr_q    <= '0;
            o_byte_ready_w <= 1'b0;
            o_we_w         <= 1'b0;
            o_addr_w       <= '0;
            o_wdata_w      <= '0;
            o_cpu_rst_w    <= 1'b1;
            o_done_w       <= 1'b0;
            o_error_w      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start_ok) begin
                        state_q        <= COUNT;
                        o_byte_ready_w <= 1'b1;
                        o_addr_w       <= '0;
                        o_cpu_rst_w    <= 1'b1;
                        o_done_w       <= 1'b0;
                        o_error_w      <= 1'b0;
                    end
                end
                COUNT: begin
                    if (transfer) begin
                        if (count_bad) begin
                            state_q        <= ERROR;
                            o_byte_ready_w <= 1'b0;
                            o_error_w      <= 1'b1;
                        end else begin
                            // Keep the index of the final word rather than N,
                            // so N == DEPTH still fits in ADDR_W bits.
                            last_addr_q <= ADDR_W'(i_byte_w - 8'd1);
                            state_q     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (asm_word_ready) begin
                        state_q        <= WRITE;
                        o_byte_ready_w <= 1'b0;
                        o_we_w         <= 1'b1;
                        o_wdata_w      <= WORD_W'(asm_word);
                    end
                end
                WRITE: begin
                    o_we_w         <= 1'b0;
                    o_byte_ready_w <= 1'b1;
                    if (o_addr_w == last_addr_q) begin
                        state_q <= CHECK;
                    end else begin
                        o_addr_w <= o_addr_w + ADDR_W'(1);
                        state_q  <= DATA;
                    end
                end
                CHECK: begin
                    if (transfer) begin
                        o_byte_ready_w <= 1'b0;
                        if (i_byte_w == asm_checksum) begin
                            state_q     <= DONE;
                            o_done_w    <= 1'b1;
                            o_cpu_rst_w <= 1'b0;
                        end else begin
                            state_q   <= ERROR;
                            o_error_w <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    o_byte_ready_w <= 1'b0;
                    o_we_w         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: drives byte images over the
// valid/ready handshake and checks IMEM writes and status outputs.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    // Log of observed IMEM writes and handshake violations.
    logic [5:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          ready_in_write = 0;

    imem_loader dut (
        .i_clk_w        (clk),
        .i_rst_w        (rst),
        .i_start_w      (start),
        .i_byte_valid_w (byte_valid),
        .i_byte_w       (byte_data),
        .o_byte_ready_w (byte_ready),
        .o_we_w         (we),
        .o_addr_w       (addr),
        .o_wdata_w      (wdata),
        .o_cpu_rst_w    (cpu_rst),
        .o_done_w       (done),
        .o_error_w      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe and flag ready asserted during a write cycle.
    always @(negedge clk) begin
        if (we) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
            if (byte_ready) ready_in_write++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        ready_in_write = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present a byte after 'gap' idle cycles and return right after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic go_idle();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    logic [31:0] big_word;
    logic [7:0]  big_csum;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ready",   {31'd0, byte_ready}, 32'd0);
        check("rst_we",      {31'd0, we},         32'd0);
        check("rst_addr",    {26'd0, addr},       32'd0);
        check("rst_wdata",   wdata,               32'd0);
        check("rst_cpu_rst", {31'd0, cpu_rst},    32'd1);
        check("rst_done",    {31'd0, done},       32'd0);
        check("rst_error",   {31'd0, error},      32'd0);
        rst = 1'b0;

        // Two-word image, good checksum, valid held high
        clear_log();
        pulse_start();
        check("start_ready", {31'd0, byte_ready}, 32'd1);
        send_byte(8'h02, 0);
        send_word(32'h20080005, 0);
        send_word(32'hAC080000, 0);
        send_byte(8'h89, 0);
        go_idle();
        check("ok_done",    {31'd0, done},     32'd1);
        check("ok_cpu_rst", {31'd0, cpu_rst},  32'd0);
        check("ok_error",   {31'd0, error},    32'd0);
        check("ok_ready",   {31'd0, byte_ready}, 32'd0);
        check("ok_nwrites", wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check("ok_addr0", {26'd0, wr_addr_q[0]}, 32'd0);
            check("ok_data0", wr_data_q[0],          32'h20080005);
            check("ok_addr1", {26'd0, wr_addr_q[1]}, 32'd1);
            check("ok_data1", wr_data_q[1],          32'hAC080000);
        end
        check("ok_no_ready_in_write", ready_in_write, 32'd0);

        // Same image, wrong checksum
        clear_log();
        pulse_start();
        check("restart_done_cleared", {31'd0, done}, 32'd0);
        send_byte(8'h02, 0);
        send_word(32'h20080005, 0);
        send_word(32'hAC080000, 0);
        send_byte(8'h00, 0);
        go_idle();
        check("bad_error",   {31'd0, error},   32'd1);
        check("bad_done",    {31'd0, done},    32'd0);
        check("bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("bad_nwrites", wr_addr_q.size(), 32'd2);
        if (wr_data_q.size() == 2) begin
            check("bad_data0", wr_data_q[0], 32'h20080005);
            check("bad_data1", wr_data_q[1], 32'hAC080000);
        end

        // Count byte zero
        clear_log();
        pulse_start();
        check("cnt0_error_cleared", {31'd0, error}, 32'd0);
        send_byte(8'h00, 0);
        go_idle();
        check("cnt0_error", {31'd0, error},      32'd1);
        check("cnt0_ready", {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        check("cnt0_ready_hold", {31'd0, byte_ready}, 32'd0);
        check("cnt0_nwrites", wr_addr_q.size(), 32'd0);

        // Count byte 65, one past DEPTH
        clear_log();
        pulse_start();
        send_byte(8'h41, 0);
        go_idle();
        check("cnt65_error", {31'd0, error},      32'd1);
        check("cnt65_ready", {31'd0, byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("cnt65_nwrites", wr_addr_q.size(), 32'd0);

        // Full DEPTH image with random valid gaps
        clear_log();
        big_csum = 8'h00;
        pulse_start();
        send_byte(8'h40, $urandom_range(0, 3));
        for (int i = 0; i < 64; i++) begin
            big_word = 32'h01020304 * (i + 1) ^ {i[7:0], 8'hA5, i[7:0], 8'h3C};
            big_csum = big_csum ^ big_word[31:24] ^ big_word[23:16] ^ big_word[15:8] ^ big_word[7:0];
            send_word(big_word, $urandom_range(0, 3));
        end
        send_byte(big_csum, $urandom_range(0, 3));
        go_idle();
        check("full_done",    {31'd0, done},    32'd1);
        check("full_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("full_nwrites", wr_addr_q.size(), 32'd64);
        check("full_no_ready_in_write", ready_in_write, 32'd0);
        if (wr_addr_q.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                big_word = 32'h01020304 * (i + 1) ^ {i[7:0], 8'hA5, i[7:0], 8'h3C};
                check($sformatf("full_addr%0d", i), {26'd0, wr_addr_q[i]}, i);
                check($sformatf("full_data%0d", i), wr_data_q[i], big_word);
            end
        end

        // Reset after the 2nd byte of word 3
        clear_log();
        pulse_start();
        send_byte(8'h04, 0);
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        send_word(32'h33333333, 0);
        send_byte(8'h44, 0);
        send_byte(8'h44, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check("mid_rst_ready",   {31'd0, byte_ready}, 32'd0);
        check("mid_rst_we",      {31'd0, we},         32'd0);
        check("mid_rst_addr",    {26'd0, addr},       32'd0);
        check("mid_rst_wdata",   wdata,               32'd0);
        check("mid_rst_cpu_rst", {31'd0, cpu_rst},    32'd1);
        check("mid_rst_done",    {31'd0, done},       32'd0);
        check("mid_rst_error",   {31'd0, error},      32'd0);
        check("mid_rst_nwrites", wr_addr_q.size(),    32'd3);
        rst = 1'b0;
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_word(32'hDEADBEEF, 0);
        send_byte(8'h22, 0);
        go_idle();
        check("after_rst_done",    {31'd0, done},   32'd1);
        check("after_rst_nwrites", wr_addr_q.size(), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check("after_rst_addr", {26'd0, wr_addr_q[0]}, 32'd0);
            check("after_rst_data", wr_data_q[0],          32'hDEADBEEF);
        end

        // Start pulsed mid-DATA is ignored
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        go_idle();
        pulse_start();
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        send_byte(8'h08, 0);
        go_idle();
        check("ign_start_done",    {31'd0, done},    32'd1);
        check("ign_start_error",   {31'd0, error},   32'd0);
        check("ign_start_nwrites", wr_addr_q.size(), 32'd1);
        if (wr_data_q.size() == 1) begin
            check("ign_start_data", wr_data_q[0], 32'h12345678);
        end

        // Start in DONE restarts the load
        pulse_start();
        check("redo_done",    {31'd0, done},       32'd0);
        check("redo_cpu_rst", {31'd0, cpu_rst},    32'd1);
        check("redo_ready",   {31'd0, byte_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
